serial_adder: RTL

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_if.sv | 26 ++
 rtl/serial_adder.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/serial_adder_if.sv
// Bus bundle for serial_adder: operands and mode go in, status and results come out.
// The master drives the request side; the slave (the adder) drives the result side.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ovf;

    modport master (
        output start, sub, a, b, ci,
        input  busy, done, s, co, ovf
    );

    modport slave (
        input  start, sub, a, b, ci,
        output busy, done, s, co, ovf
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder stage plus a carry flop, LSB first.
// An operation takes WIDTH ADD cycles followed by a single DONE cycle. Subtraction
// is a + ~b + ~borrow_in, so co=1 means "no borrow". All outputs come from flops.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_adder_if.slave  bus
);

    localparam int                CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Full-adder sum bit.
    function automatic logic fa_sum(input logic x, input logic y, input logic c);
        return x ^ y ^ c;
    endfunction

    // Full-adder carry: majority of the three inputs.
    function automatic logic fa_carry(input logic x, input logic y, input logic c);
        return (x & y) | (x & c) | (y & c);
    endfunction

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    // Holds the WIDTH-1 low result bits; the last bit goes straight into s.
    logic [WIDTH-2:0]   res_q, res_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic               co_q, co_d;
    logic               ovf_q, ovf_d;

    logic               sum_bit_s;
    logic               carry_out_s;

    // Single full-adder stage working on the current LSBs and the stored carry.
    always_comb begin
        sum_bit_s   = fa_sum(a_sr_q[0], b_sr_q[0], carry_q);
        carry_out_s = fa_carry(a_sr_q[0], b_sr_q[0], carry_q);
    end

    // Next-state, datapath and output-register update logic.
    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        co_d    = co_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = ADD;
                    a_sr_d  = bus.a;
                    // Subtract by adding the one's complement with inverted borrow-in.
                    b_sr_d  = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.ci ^ bus.sub;
                    cnt_d   = '0;
                    res_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end

            ADD: begin
                a_sr_d  = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d  = {1'b0, b_sr_q[WIDTH-1:1]};
                res_d   = (WIDTH-1)'({sum_bit_s, res_q} >> 1);
                carry_d = carry_out_s;
                if (cnt_q == LAST_BIT) begin
                    // MSB edge: publish the result; carry_q is the carry into the MSB.
                    state_d = DONE;
                    s_d     = {sum_bit_s, res_q};
                    co_d    = carry_out_s;
                    ovf_d   = carry_q ^ carry_out_s;
                end else begin
                    state_d = ADD;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end

            DONE: begin
                // start is deliberately ignored here; a new request is taken in IDLE.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Status flags are registered versions of the next state.
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State, datapath and output registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            s_q     <= '0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            s_q     <= s_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.s    = s_q;
    assign bus.co   = co_q;
    assign bus.ovf  = ovf_q;

endmodule
